// File: rtl/count_ctrl_3bit_if.sv
// Control/status bundle for count_ctrl_3bit.
// The dir signal exists only when COUNT_DOWN_EN is defined.
interface count_ctrl_3bit_if;
    logic       start;
    logic       stop;
    logic       mode_cont;
    logic [2:0] limit;
`ifdef COUNT_DOWN_EN
    logic       dir;
`endif
    logic [2:0] q;
    logic       busy;
    logic       done;

    modport master (
        output start, stop, mode_cont, limit,
`ifdef COUNT_DOWN_EN
        output dir,
`endif
        input  q, busy, done
    );

    modport slave (
        input  start, stop, mode_cont, limit,
`ifdef COUNT_DOWN_EN
        input  dir,
`endif
        output q, busy, done
    );
endinterface

// File: rtl/count_ctrl_3bit.sv
// 3-bit run/hold/done counter controller with one-shot or wrapping runs.
// Optional down-counting is enabled by defining COUNT_DOWN_EN.
module count_ctrl_3bit (
    input  logic              clk,
    input  logic              reset,
    count_ctrl_3bit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

    state_t     state_q;
    logic [2:0] q_q;
    logic [2:0] limit_q;
    logic       mode_q;
    logic       busy_q;
    logic       done_q;

    logic       down_d;
    logic       go_d;
    logic       at_term_d;
    logic [2:0] step_d;
    logic [2:0] reload_d;
    logic [2:0] load_d;

`ifdef COUNT_DOWN_EN
    logic       dir_q;
    assign down_d = dir_q;
    assign load_d = bus.dir ? bus.limit : 3'd0;
`else
    assign down_d = 1'b0;
    assign load_d = 3'd0;
`endif

    // Terminal value is limit when counting up, zero when counting down.
    always_comb begin
        go_d      = bus.start & ~bus.stop;
        at_term_d = down_d ? (q_q == 3'd0) : (q_q == limit_q);
        step_d    = down_d ? (q_q - 3'd1) : (q_q + 3'd1);
        reload_d  = down_d ? limit_q : 3'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            q_q     <= 3'd0;
            limit_q <= 3'd0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef COUNT_DOWN_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (go_d) begin
                        limit_q <= bus.limit;
                        mode_q  <= bus.mode_cont;
`ifdef COUNT_DOWN_EN
                        dir_q   <= bus.dir;
`endif
                        q_q     <= load_d;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state_q <= HOLD;
                    end else if (at_term_d) begin
                        done_q <= 1'b1;
                        if (mode_q) begin
                            q_q <= reload_d;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= DONE;
                        end
                    end else begin
                        q_q <= step_d;
                    end
                end
                HOLD: begin
                    // A second stop abandons the run without a done pulse.
                    if (bus.stop) begin
                        q_q     <= 3'd0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (bus.start) begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.q    = q_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
